// File: rtl/ex_multicycle.sv
// Execute stage: single-cycle logic/shift ALU plus a multi-cycle restoring
// divider (DIV/DIVU) that stalls the pipeline until the quotient/remainder are ready.
module ex_multicycle #(
    parameter int DATA_W  = 32,
    parameter int SHAMT_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] rdata1_i,
    input  logic [DATA_W-1:0] rdata2_i,
    input  logic [4:0]        waddr_reg_i,
    input  logic              we_reg_i,
    input  logic              annul_i,
    output logic [4:0]        waddr_reg_o,
    output logic              we_reg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stall_req_o
);

    localparam logic [7:0] OP_AND  = 8'b0010_0100;
    localparam logic [7:0] OP_OR   = 8'b0010_0101;
    localparam logic [7:0] OP_XOR  = 8'b0010_0110;
    localparam logic [7:0] OP_NOR  = 8'b0010_0111;
    localparam logic [7:0] OP_SLL  = 8'b0111_1100;
    localparam logic [7:0] OP_SRL  = 8'b0000_0010;
    localparam logic [7:0] OP_SRA  = 8'b0000_0011;
    localparam logic [7:0] OP_DIV  = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU = 8'b0001_1011;

    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;

    localparam logic [SHAMT_W:0] CNT_FULL = (SHAMT_W+1)'(DATA_W);
    localparam logic [SHAMT_W:0] CNT_ONE  = (SHAMT_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    div_state_t        state_q, state_nxt;
    logic [SHAMT_W:0]  cnt_q, cnt_nxt;
    logic [DATA_W-1:0] dvd_q, dvd_nxt;
    logic [DATA_W-1:0] dvs_q, dvs_nxt;
    logic [DATA_W-1:0] rem_q, rem_nxt;
    logic              qneg_q, qneg_nxt;
    logic              rneg_q, rneg_nxt;

    logic              is_div, is_sdiv;
    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W:0]   rem_sh, diff;
    logic [DATA_W-1:0] logic_res, shift_res;
    logic [DATA_W-1:0] quo_fix, rem_fix;
    logic [SHAMT_W-1:0] shamt;

    assign is_div  = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
    assign is_sdiv = (aluop_i == OP_DIV);
    assign a_neg   = is_sdiv & rdata1_i[DATA_W-1];
    assign b_neg   = is_sdiv & rdata2_i[DATA_W-1];
    assign a_mag   = a_neg ? ('0 - rdata1_i) : rdata1_i;
    assign b_mag   = b_neg ? ('0 - rdata2_i) : rdata2_i;
    assign shamt   = rdata2_i[SHAMT_W-1:0];

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            OP_OR:   logic_res = rdata1_i | rdata2_i;
            OP_AND:  logic_res = rdata1_i & rdata2_i;
            OP_NOR:  logic_res = ~(rdata1_i | rdata2_i);
            OP_XOR:  logic_res = rdata1_i ^ rdata2_i;
            default: logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_i)
            OP_SLL:  shift_res = rdata1_i << shamt;
            OP_SRL:  shift_res = rdata1_i >> shamt;
            OP_SRA:  shift_res = $signed(rdata1_i) >>> shamt;
            default: shift_res = '0;
        endcase
    end

    // Remainder is kept one bit wider during the trial subtract so its sign shows the borrow.
    assign rem_sh = {rem_q, dvd_q[DATA_W-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        dvd_nxt   = dvd_q;
        dvs_nxt   = dvs_q;
        rem_nxt   = rem_q;
        qneg_nxt  = qneg_q;
        rneg_nxt  = rneg_q;
        case (state_q)
            IDLE: begin
                if (is_div && !annul_i) begin
                    qneg_nxt = a_neg ^ b_neg;
                    rneg_nxt = a_neg;
                    dvs_nxt  = b_mag;
                    rem_nxt  = '0;
                    if (rdata2_i == '0) begin
                        dvd_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        dvd_nxt   = a_mag;
                        cnt_nxt   = CNT_FULL;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!diff[DATA_W]) begin
                    rem_nxt = diff[DATA_W-1:0];
                    dvd_nxt = {dvd_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_nxt = rem_sh[DATA_W-1:0];
                    dvd_nxt = {dvd_q[DATA_W-2:0], 1'b0};
                end
                cnt_nxt = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (annul_i) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            dvd_q   <= dvd_nxt;
            dvs_q   <= dvs_nxt;
            rem_q   <= rem_nxt;
            qneg_q  <= qneg_nxt;
            rneg_q  <= rneg_nxt;
        end
    end

    assign quo_fix = qneg_q ? ('0 - dvd_q) : dvd_q;
    assign rem_fix = rneg_q ? ('0 - rem_q) : rem_q;

    always_comb begin
        waddr_reg_o = '0;
        we_reg_o    = 1'b0;
        wdata_o     = '0;
        whilo_o     = 1'b0;
        hi_o        = '0;
        lo_o        = '0;
        stall_req_o = 1'b0;
        if (!rst) begin
            waddr_reg_o = waddr_reg_i;
            we_reg_o    = we_reg_i & ~is_div;
            case (alusel_i)
                SEL_LOGIC: wdata_o = logic_res;
                SEL_SHIFT: wdata_o = shift_res;
                default:   wdata_o = '0;
            endcase
            if (state_q == DONE) begin
                hi_o    = rem_fix;
                lo_o    = quo_fix;
                whilo_o = ~annul_i;
            end
            stall_req_o = is_div && (state_q != DONE) && !annul_i;
        end
    end

endmodule
